// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: request opcode fields,
// access sizes, FSM states and the halfword extension helper.
package mem_access_pkg;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int OP_SZ_HI = 1;
  localparam int OP_SZ_LO = 0;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic [31:0] sign_extension(input logic [15:0] val, input logic zero_ext);
    return zero_ext ? {16'h0000, val} : {{16{val[15]}}, val};
  endfunction

endpackage

// File: rtl/load_data_extender.sv
// Combinational big-endian lane select and sign/zero extension of a loaded word.
module load_data_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Offset 0 is the most significant byte.
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    case (size)
      SZ_BYTE: ext = is_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: ext = sign_extension(half_sel, is_unsigned);
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: one outstanding request, registered memory port,
// byte-enable/lane generation on stores and extended read data on loads.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_Valid,
  output logic              req_Ready,
  input  logic [3:0]        req_Op,
  input  logic [ADDR_W-1:0] req_Addr,
  input  logic [31:0]       req_Wdata,
  output logic              rsp_Valid,
  output logic [31:0]       rsp_Rdata,
  output logic              rsp_Err,
  output logic              mem_Valid,
  input  logic              mem_Ready,
  output logic              mem_We,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [3:0]        mem_Be,
  output logic [31:0]       mem_Wdata,
  input  logic              mem_Rvalid,
  input  logic [31:0]       mem_Rdata
);

  state_t      state;
  logic [1:0]  req_size;
  logic [1:0]  req_off;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wd;

  logic        cap_uns;
  logic [1:0]  cap_size;
  logic [1:0]  cap_off;
  logic [31:0] load_ext;

  assign req_size = req_Op[OP_SZ_HI:OP_SZ_LO];
  assign req_off  = req_Addr[1:0];

  always_comb begin
    req_err = 1'b0;
    req_be  = 4'b0000;
    req_wd  = req_Wdata;
    case (req_size)
      SZ_BYTE: begin
        req_be = 4'b1000 >> req_off;
        req_wd = {4{req_Wdata[7:0]}};
      end
      SZ_HALF: begin
        req_be  = req_off[1] ? 4'b0011 : 4'b1100;
        req_wd  = {2{req_Wdata[15:0]}};
        req_err = req_off[0];
      end
      SZ_WORD: begin
        req_be  = 4'b1111;
        req_err = |req_off;
      end
      default: req_err = 1'b1;
    endcase
  end

  load_data_extender u_ext (
    .rdata       (mem_Rdata),
    .offset      (cap_off),
    .size        (cap_size),
    .is_unsigned (cap_uns),
    .ext         (load_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_Ready <= 1'b1;
      rsp_Valid <= 1'b0;
      rsp_Rdata <= 32'h0;
      rsp_Err   <= 1'b0;
      mem_Valid <= 1'b0;
      mem_We    <= 1'b0;
      mem_Addr  <= '0;
      mem_Be    <= 4'b0000;
      mem_Wdata <= 32'h0;
      cap_uns   <= 1'b0;
      cap_size  <= 2'd0;
      cap_off   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_Valid) begin
            req_Ready <= 1'b0;
            cap_uns   <= req_Op[OP_UNS];
            cap_size  <= req_size;
            cap_off   <= req_off;
            if (req_err) begin
              state     <= RESP;
              rsp_Valid <= 1'b1;
              rsp_Err   <= 1'b1;
            end else begin
              state     <= ISSUE;
              mem_Valid <= 1'b1;
              mem_We    <= req_Op[OP_STORE];
              mem_Addr  <= {req_Addr[ADDR_W-1:2], 2'b00};
              mem_Be    <= req_be;
              mem_Wdata <= req_Op[OP_STORE] ? req_wd : 32'h0;
            end
          end
        end
        ISSUE: begin
          if (mem_Ready) begin
            mem_Valid <= 1'b0;
            mem_We    <= 1'b0;
            mem_Addr  <= '0;
            mem_Be    <= 4'b0000;
            mem_Wdata <= 32'h0;
            if (mem_We) begin
              state     <= RESP;
              rsp_Valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_Rvalid) begin
            rsp_Rdata <= load_ext;
            rsp_Valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_Valid <= 1'b0;
          rsp_Rdata <= 32'h0;
          rsp_Err   <= 1'b0;
          req_Ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small big-endian memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_Valid;
  logic        req_Ready;
  logic [3:0]  req_Op;
  logic [31:0] req_Addr;
  logic [31:0] req_Wdata;
  logic        rsp_Valid;
  logic [31:0] rsp_Rdata;
  logic        rsp_Err;
  logic        mem_Valid;
  logic        mem_Ready;
  logic        mem_We;
  logic [31:0] mem_Addr;
  logic [3:0]  mem_Be;
  logic [31:0] mem_Wdata;
  logic        mem_Rvalid;
  logic [31:0] mem_Rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_Valid(req_Valid), .req_Ready(req_Ready), .req_Op(req_Op),
    .req_Addr(req_Addr), .req_Wdata(req_Wdata),
    .rsp_Valid(rsp_Valid), .rsp_Rdata(rsp_Rdata), .rsp_Err(rsp_Err),
    .mem_Valid(mem_Valid), .mem_Ready(mem_Ready), .mem_We(mem_We),
    .mem_Addr(mem_Addr), .mem_Be(mem_Be), .mem_Wdata(mem_Wdata),
    .mem_Rvalid(mem_Rvalid), .mem_Rdata(mem_Rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  rsp_exp_t    sbq[$];
  mem_exp_t    mexp[$];
  logic [31:0] mem [int];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rsp_cyc = -10;
  int accept_cnt = 0;
  int stall_cfg = 0;
  int stall_cnt = 0;
  bit rdy_driven = 0;
  bit no_rdata = 0;
  bit force_rvalid = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    return mem.exists(idx) ? mem[idx] : 32'h0;
  endfunction

  // Memory model: optional stall before mem_Ready, read data the cycle after acceptance.
  always @(negedge clk) begin
    mem_exp_t m;
    int idx;
    logic [31:0] w;
    mem_Rvalid = 1'b0;
    mem_Rdata  = 32'hDEADBEEF;
    if (force_rvalid) begin
      mem_Rvalid = 1'b1;
      mem_Rdata  = 32'h80017FFE;
    end
    if (reset) begin
      mem_Ready  = 1'b0;
      rdy_driven = 0;
      stall_cnt  = 0;
    end else if (rdy_driven) begin
      mem_Ready  = 1'b0;
      rdy_driven = 0;
      stall_cnt  = 0;
      accept_cnt++;
      if (mexp.size() != 0) begin
        m = mexp.pop_front();
        if (m.we) begin
          idx = int'(m.addr >> 2);
          w = mem_rd(m.addr);
          for (int i = 0; i < 4; i++)
            if (m.be[i]) w[8*i +: 8] = m.wdata[8*i +: 8];
          mem[idx] = w;
        end else if (!no_rdata) begin
          mem_Rvalid = 1'b1;
          mem_Rdata  = mem_rd(m.addr);
        end
      end
    end else if (mem_Valid) begin
      if (mexp.size() == 0) begin
        chk("unexpected_mem_valid", {31'h0, mem_Valid}, 32'h0);
      end else begin
        chk("mem_addr", mem_Addr, mexp[0].addr);
        chk("mem_be", {28'h0, mem_Be}, {28'h0, mexp[0].be});
        chk("mem_we", {31'h0, mem_We}, {31'h0, mexp[0].we});
        chk("mem_wdata", mem_Wdata, mexp[0].wdata);
        chk("req_ready_busy", {31'h0, req_Ready}, 32'h0);
      end
      if (stall_cnt >= stall_cfg) begin
        mem_Ready  = 1'b1;
        rdy_driven = 1;
      end else begin
        stall_cnt++;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_exp_t e;
    if (!reset) begin
      if (rsp_Valid) begin
        last_rsp_cyc = cyc;
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", {31'h0, rsp_Valid}, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_Rdata, e.rdata);
          chk("rsp_err", {31'h0, rsp_Err}, {31'h0, e.err});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end else begin
        chk("rsp_idle_zero", {rsp_Rdata[31:1], rsp_Rdata[0] | rsp_Err}, 32'h0);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input int stall, input logic [3:0] e_be, input logic [31:0] e_wdata,
                       input logic [31:0] e_rdata, input logic e_err,
                       input bit hold, input bit b2b, input bit no_rsp);
    int n;
    int acc;
    int lat;
    rsp_exp_t r;
    mem_exp_t m;
    @(negedge clk);
    req_Valid = 1'b1;
    req_Op    = op;
    req_Addr  = addr;
    req_Wdata = wdata;
    n = 0;
    while (!req_Ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept_timeout", {31'h0, req_Ready}, 32'h1);
    stall_cfg = stall;
    acc = cyc;
    if (b2b) chk("b2b_accept_cycle", acc, last_rsp_cyc + 1);
    lat = e_err ? 1 : (op[3] ? 2 + stall : 3 + stall);
    if (!no_rsp) begin
      r.rdata = e_rdata;
      r.err   = e_err;
      r.cyc   = acc + lat;
      sbq.push_back(r);
    end
    if (!e_err) begin
      m.addr  = {addr[31:2], 2'b00};
      m.be    = e_be;
      m.we    = op[3];
      m.wdata = e_wdata;
      mexp.push_back(m);
    end
    @(posedge clk);
    #1;
    if (!hold) req_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || mexp.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'h0, n < 100}, 32'h1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int acc0;
    reset     = 1'b1;
    req_Valid = 1'b0;
    req_Op    = 4'h0;
    req_Addr  = 32'h0;
    req_Wdata = 32'h0;
    mem_Ready = 1'b0;
    mem_Rvalid = 1'b0;
    mem_Rdata = 32'h0;
    mem[32'h100 >> 2] = 32'h80017FFE;
    #2;
    chk("reset_req_ready", {31'h0, req_Ready}, 32'h1);
    chk("reset_mem_valid", {31'h0, mem_Valid}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_Valid}, 32'h0);
    chk("reset_mem_fields", mem_Addr | mem_Wdata | {27'h0, mem_Be, mem_We}, 32'h0);
    chk("reset_rsp_fields", rsp_Rdata | {31'h0, rsp_Err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Loads from 0x80017FFE
    issue(4'b0000, 32'h100, 32'h0, 0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 0, 0, 0); drain();
    issue(4'b0100, 32'h101, 32'h0, 0, 4'b0100, 32'h0, 32'h00000001, 1'b0, 0, 0, 0); drain();
    issue(4'b0001, 32'h102, 32'h0, 0, 4'b0011, 32'h0, 32'h00007FFE, 1'b0, 0, 0, 0); drain();
    issue(4'b0101, 32'h100, 32'h0, 0, 4'b1100, 32'h0, 32'h00008001, 1'b0, 0, 0, 0); drain();
    issue(4'b0010, 32'h100, 32'h0, 0, 4'b1111, 32'h0, 32'h80017FFE, 1'b0, 0, 0, 0); drain();

    // SB then read the stored byte back both ways
    issue(4'b1000, 32'h103, 32'h123456AB, 0, 4'b0001, 32'hABABABAB, 32'h0, 1'b0, 0, 0, 0); drain();
    issue(4'b0100, 32'h103, 32'h0, 0, 4'b0001, 32'h0, 32'h000000AB, 1'b0, 0, 0, 0); drain();
    issue(4'b0000, 32'h103, 32'h0, 0, 4'b0001, 32'h0, 32'hFFFFFFAB, 1'b0, 0, 0, 0); drain();

    // Misaligned / illegal requests
    issue(4'b0010, 32'h102, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 0, 0); drain();
    issue(4'b0001, 32'h101, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 0, 0); drain();
    issue(4'b0011, 32'h100, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 0, 0); drain();

    // SH with three memory wait states, then confirm the merged word
    issue(4'b1001, 32'h102, 32'h0000BEEF, 3, 4'b0011, 32'hBEEFBEEF, 32'h0, 1'b0, 0, 0, 0); drain();
    issue(4'b0010, 32'h100, 32'h0, 0, 4'b1111, 32'h0, 32'h8001BEEF, 1'b0, 0, 0, 0); drain();

    // Reset while a load waits for read data; a late mem_Rvalid must be ignored
    no_rdata = 1;
    acc0 = accept_cnt;
    issue(4'b0000, 32'h100, 32'h0, 0, 4'b1000, 32'h0, 32'h0, 1'b0, 0, 0, 1);
    n = 0;
    while (accept_cnt == acc0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_accept_timeout", {31'h0, n < 50}, 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_req_ready", {31'h0, req_Ready}, 32'h1);
    chk("async_rst_mem_valid", {31'h0, mem_Valid}, 32'h0);
    chk("async_rst_rsp_valid", {31'h0, rsp_Valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    no_rdata = 0;
    @(posedge clk);
    #1 force_rvalid = 1;
    @(posedge clk);
    #1 force_rvalid = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_req_ready", {31'h0, req_Ready}, 32'h1);
    chk("post_rst_rsp_valid", {31'h0, rsp_Valid}, 32'h0);

    // Back-to-back SW then LW with req_Valid held high
    issue(4'b1010, 32'h200, 32'h13579BDF, 0, 4'b1111, 32'h13579BDF, 32'h0, 1'b0, 1, 0, 0);
    issue(4'b0010, 32'h200, 32'h0, 0, 4'b1111, 32'h0, 32'h13579BDF, 1'b0, 0, 1, 0);
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential data-memory access unit between the MIPS datapath and the data memory port. Stores narrow 32-bit register data to byte/halfword lanes with byte enables. Loads extract the addressed byte or halfword from the returned word and sign- or zero-extend it to 32 bits. It owns the memory valid/ready handshake, detects misalignment, and returns one response per accepted request.

## Interface
- ADDR_W, 32, byte-address width; the memory address is word-aligned.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_Valid  in  1  CPU request present.
- req_Ready  out  1  unit idle and able to accept a request.
- req_Op  in  4  request operation, encoded {store, unsigned, size[1:0]}.
  - size 0 = byte, 1 = half, 2 = word, 3 = illegal.
  - The unsigned bit is ignored for stores and for word loads.
- req_Addr  in  ADDR_W  byte address.
- req_Wdata  in  32  store data; the low byte or halfword is used for narrow stores.
- rsp_Valid  out  1  single-cycle response pulse.
- rsp_Rdata  out  32  extended load data; 0 for stores and errors.
- rsp_Err  out  1  misaligned or illegal request; valid with rsp_Valid.
- mem_Valid  out  1  memory request.
- mem_Ready  in  1  memory accepts the request.
- mem_We  out  1  write strobe.
- mem_Addr  out  ADDR_W  req_Addr with [1:0] forced to 0.
- mem_Be  out  4  byte enables; bit 3 = bits [31:24].
- mem_Wdata  out  32  lane-replicated store data.
- mem_Rvalid  in  1  read data valid.
- mem_Rdata  in  32  read word.

## Operation
- Byte order is big-endian. Byte offset k (addr[1:0]) occupies bits [31-8k : 24-8k].
- Byte enables:
  - byte: mem_Be = 4'b1000 >> k.
  - half: offset 0 gives 4'b1100; offset 2 gives 4'b0011.
  - word: 4'b1111.
  - Loads drive the same byte-enable pattern.
- Store data replication:
  - sb: {4{req_Wdata[7:0]}}.
  - sh: {2{req_Wdata[15:0]}}.
  - sw: req_Wdata.
- Load extraction:
  - byte/half lanes are selected by offset.
  - The selected data is sign-extended when unsigned=0 and zero-extended when unsigned=1.
  - Word loads pass mem_Rdata through.
- Error condition: size=3, half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory transaction is issued.
  - Response has rsp_Err=1 and rsp_Rdata=0.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: req_Ready=1. On req_Valid, the request is captured and all mem_* outputs are registered. Next state is RESP if the request is in error, otherwise ISSUE.
  - ISSUE: mem_Valid=1; all mem_* outputs are held stable. On mem_Ready, a store goes to RESP and a load goes to WAIT.
  - WAIT: on mem_Rvalid, the extracted data is captured into rsp_Rdata and the state goes to RESP. mem_Rvalid is ignored in every other state.
  - RESP: rsp_Valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- Only one request is outstanding at a time. req_Ready=0 in every state other than IDLE.

## Timing
- Request accepted at edge 0:
  - mem_Valid is high from cycle 1.
  - Error response: rsp_Valid in cycle 1.
  - Store with mem_Ready in cycle 1: rsp_Valid in cycle 2.
  - Load with mem_Ready in cycle 1 and mem_Rvalid in cycle 2: rsp_Valid in cycle 3.
- The minimum request-to-request interval is 2 cycles (error) or 3 cycles (store). req_Ready returns high in the cycle after rsp_Valid.
- Memory wait states: while mem_Ready=0, mem_Valid, mem_Addr, mem_Be, mem_We and mem_Wdata are unchanged.
- Response data: rsp_Rdata and rsp_Err are valid only while rsp_Valid=1 and are 0 otherwise.
- Reset values: state=IDLE, req_Ready=1, and all other outputs 0.
- Reset asserted mid-operation: the transaction is abandoned and mem_Valid drops asynchronously. No response is produced, and a late mem_Rvalid after reset is ignored.

## Structure
- Package mem_access_pkg holds:
  - the req_Op field positions;
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module load_data_extender is purely combinational.
  - Inputs: rdata[31:0], offset[1:0], size, unsigned.
  - Output: ext[31:0].
  - It reuses sign_extension for the halfword path.
- The top level contains the FSM, the request capture registers and the lane/byte-enable generation.

## Test plan
- Memory word at 0x100 = 0x80017FFE; perform each load in turn:
  - LB @0x100 → 0xFFFFFF80.
  - LBU @0x101 → 0x00000001.
  - LH @0x102 → 0x00007FFE.
  - LHU @0x100 → 0x00008001.
  - LW @0x100 → 0x80017FFE.
- SB Wdata=0x123456AB @0x103 → mem_Addr=0x100, mem_Be=0001, mem_Wdata=0xABABABAB, mem_We=1. rsp_Valid in cycle 2 with Rdata=0.
- Error requests (LW @0x102, LH @0x101, size=3): rsp_Valid with rsp_Err=1 in cycle 1; mem_Valid never asserts.
- SH Wdata=0xBEEF @0x102 with mem_Ready low for 3 cycles → mem_Be=0011 and mem_Wdata=0xBEEFBEEF held stable; req_Ready=0 throughout; rsp_Valid 1 cycle after mem_Ready.
- LB in WAIT, reset pulsed, then mem_Rvalid → all outputs at reset values, no rsp_Valid, req_Ready=1 after reset releases.
- Back-to-back: SW then LW to the same address, req_Valid held high → the second request is accepted the cycle after the first rsp_Valid, and readback equals the written word.
